// File: rtl/rdc_fault_monitor.sv
//-----------------------------------------------------------------------------
// rdc_fault_monitor
//
// Fault-detection and register bank for the resolver-to-digital converter.
// Watches the sin/cos ADC sample streams, measures per-window peak
// magnitudes and raises sticky clipping, loss-of-signal, overrange and
// sin/cos mismatch flags. Thresholds, enable mask and error clear are
// reached through a strobe-based register interface.
//
// Optional feature macro: RDC_CLIP_DETECT_EN
//   defined   -> clipping comparator drives error bit 0
//   undefined -> no clip logic, bit 0 is always 0
//
// Ports:
//   clk_i        system clock (only clock)
//   reset_i      synchronous, active-high reset
//   sin_signal_i sin channel sample, two's complement, one per clock
//   cos_signal_i cos channel sample, two's complement, one per clock
//   reg_addr_i   register address
//   reg_data_i   register write data
//   reg_write_i  write strobe (one cycle)
//   reg_read_i   read strobe (one cycle)
//   reg_data_o   registered read data, held until the next read
//   error_o      masked sticky error flags
//
// Register map:
//   0x00 ID (RO)          0x01 LOS threshold       0x02 overrange threshold
//   0x03 mismatch thresh  0x04 DOS max tracker     0x05 DOS min tracker
//   0x06 enable mask      0x07 error clear (W1C, reads 0)
//-----------------------------------------------------------------------------
module rdc_fault_monitor #(
    parameter int unsigned                ADC_RESOLUTION = 14,
    parameter int unsigned                ADDR_WIDTH     = 8,
    parameter int unsigned                DATA_WIDTH     = 32,
    parameter int unsigned                WINDOW_LEN     = 4000,
    parameter logic [DATA_WIDTH-1:0]      ID_VALUE       = 'h12345678
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ADC_RESOLUTION-1:0] sin_signal_i,
    input  logic [ADC_RESOLUTION-1:0] cos_signal_i,
    input  logic [ADDR_WIDTH-1:0]     reg_addr_i,
    input  logic [DATA_WIDTH-1:0]     reg_data_i,
    input  logic                      reg_write_i,
    input  logic                      reg_read_i,
    output logic [DATA_WIDTH-1:0]     reg_data_o,
    output logic [7:0]                error_o
);

    localparam int unsigned N  = ADC_RESOLUTION;
    localparam int unsigned CW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

    localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_LOS   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_OVR   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_MIS   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_DMAX  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_DMIN  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_MASK  = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] A_CLR   = ADDR_WIDTH'(7);

    // Magnitude as N-bit unsigned; the most negative code maps to 2^(N-1),
    // which still fits because the result is unsigned.
    function automatic logic [N-1:0] mag(input logic [N-1:0] s);
        mag = s[N-1] ? (~s + N'(1)) : s;
    endfunction

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [N-1:0] los_thr, ovr_thr, mis_thr, dos_max, dos_min;
    logic [7:0]   mask;
    logic [7:0]   latched;
    logic [7:0]   detect;
    logic [7:0]   clr_bits;

    logic         wr_los, wr_ovr, wr_mis, wr_dmax, wr_dmin, wr_mask, wr_clr;

    assign wr_los  = reg_write_i && (reg_addr_i == A_LOS);
    assign wr_ovr  = reg_write_i && (reg_addr_i == A_OVR);
    assign wr_mis  = reg_write_i && (reg_addr_i == A_MIS);
    assign wr_dmax = reg_write_i && (reg_addr_i == A_DMAX);
    assign wr_dmin = reg_write_i && (reg_addr_i == A_DMIN);
    assign wr_mask = reg_write_i && (reg_addr_i == A_MASK);
    assign wr_clr  = reg_write_i && (reg_addr_i == A_CLR);

    assign clr_bits = wr_clr ? reg_data_i[7:0] : 8'h00;

    // ------------------------------------------------------------------
    // Sample register and window peak measurement
    // ------------------------------------------------------------------
    logic [N-1:0]  sin_q, cos_q;
    logic [N-1:0]  mag_s, mag_c;
    logic [N-1:0]  acc_s, acc_c;
    logic [N-1:0]  peak_s, peak_c;
    logic [CW-1:0] win_cnt;
    logic          eval_q;

    assign mag_s = mag(sin_q);
    assign mag_c = mag(cos_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sin_q   <= '0;
            cos_q   <= '0;
            win_cnt <= '0;
            acc_s   <= '0;
            acc_c   <= '0;
            peak_s  <= '0;
            peak_c  <= '0;
            eval_q  <= 1'b0;
        end else begin
            sin_q  <= sin_signal_i;
            cos_q  <= cos_signal_i;
            eval_q <= 1'b0;
            if (win_cnt == CW'(WINDOW_LEN - 1)) begin
                // Last sample of the window is folded straight into the
                // latched peak so no sample is lost at the boundary.
                win_cnt <= '0;
                peak_s  <= (mag_s > acc_s) ? mag_s : acc_s;
                peak_c  <= (mag_c > acc_c) ? mag_c : acc_c;
                acc_s   <= '0;
                acc_c   <= '0;
                eval_q  <= 1'b1;
            end else begin
                win_cnt <= win_cnt + CW'(1);
                if (mag_s > acc_s) acc_s <= mag_s;
                if (mag_c > acc_c) acc_c <= mag_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault detection
    // ------------------------------------------------------------------
    logic [N-1:0] pmax, pmin, delta;

    assign pmax  = (peak_s >= peak_c) ? peak_s : peak_c;
    assign pmin  = (peak_s >= peak_c) ? peak_c : peak_s;
    assign delta = (peak_s >= peak_c) ? (peak_s - peak_c) : (peak_c - peak_s);

    always_comb begin
        detect = '0;
`ifdef RDC_CLIP_DETECT_EN
        detect[0] = (sin_q == MAX_POS) || (sin_q == MOST_NEG) ||
                    (cos_q == MAX_POS) || (cos_q == MOST_NEG);
`endif
        // Peak faults only exist on the cycle after a window closes.
        if (eval_q) begin
            detect[1] = (pmax < los_thr);
            detect[2] = (pmax > ovr_thr);
            detect[3] = (delta > mis_thr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            los_thr <= '0;
            ovr_thr <= MAX_POS;
            mis_thr <= MAX_POS;
            dos_max <= '0;
            dos_min <= MAX_POS;
            mask    <= '0;
            latched <= '0;
        end else begin
            if (wr_los)  los_thr <= reg_data_i[N-1:0];
            if (wr_ovr)  ovr_thr <= reg_data_i[N-1:0];
            if (wr_mis)  mis_thr <= reg_data_i[N-1:0];
            if (wr_mask) mask    <= reg_data_i[7:0];

            if (wr_dmax)                         dos_max <= reg_data_i[N-1:0];
            else if (eval_q && (pmax > dos_max)) dos_max <= pmax;

            if (wr_dmin)                         dos_min <= reg_data_i[N-1:0];
            else if (eval_q && (pmin < dos_min)) dos_min <= pmin;

            // Set term is ORed after the clear so a same-cycle detection wins.
            latched <= (latched & ~clr_bits) | (detect & mask);
        end
    end

    assign error_o = latched & mask;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            A_ID:    rd_mux = ID_VALUE;
            A_LOS:   rd_mux = DATA_WIDTH'(los_thr);
            A_OVR:   rd_mux = DATA_WIDTH'(ovr_thr);
            A_MIS:   rd_mux = DATA_WIDTH'(mis_thr);
            A_DMAX:  rd_mux = DATA_WIDTH'(dos_max);
            A_DMIN:  rd_mux = DATA_WIDTH'(dos_min);
            A_MASK:  rd_mux = DATA_WIDTH'(mask);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            reg_data_o <= '0;
        end else if (reg_read_i) begin
            reg_data_o <= rd_mux;
        end
    end

    // Write-data bits above the widest register field carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^reg_data_i[DATA_WIDTH-1:N];

endmodule

// File: tb/tb_rdc_fault_monitor.sv
module tb_rdc_fault_monitor;

    localparam int unsigned N   = 14;
    localparam int unsigned WL  = 100;
    localparam int unsigned PER = 40;

`ifdef RDC_CLIP_DETECT_EN
    localparam logic CLIP = 1'b1;
`else
    localparam logic CLIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  sin_in, cos_in;
    logic [N-1:0]  dc_sin, dc_cos, wave_sin, wave_cos;
    logic          wave_en;
    logic [7:0]    addr;
    logic [31:0]   wdata;
    logic          wr, rd;
    logic [31:0]   rdata;
    logic [7:0]    err;

    int n_cmp = 0;
    int n_bad = 0;

    assign sin_in = wave_en ? wave_sin : dc_sin;
    assign cos_in = wave_en ? wave_cos : dc_cos;

    rdc_fault_monitor #(
        .ADC_RESOLUTION (N),
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .WINDOW_LEN     (WL),
        .ID_VALUE       (32'h12345678)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .sin_signal_i (sin_in),
        .cos_signal_i (cos_in),
        .reg_addr_i   (addr),
        .reg_data_i   (wdata),
        .reg_write_i  (wr),
        .reg_read_i   (rd),
        .reg_data_o   (rdata),
        .error_o      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a);
        addr = a; rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    // Sinusoid generator: period 40 samples, amplitudes 4100 / 4076.
    logic [N-1:0] sin_tab [PER];
    logic [N-1:0] cos_tab [PER];

    initial begin
        int ph;
        real w;
        ph = 0;
        wave_sin = '0;
        wave_cos = '0;
        for (int k = 0; k < PER; k++) begin
            w = 2.0 * 3.14159265358979 * k / PER;
            sin_tab[k] = N'($rtoi($floor(4100.0 * $sin(w) + 0.5)));
            cos_tab[k] = N'($rtoi($floor(4076.0 * $cos(w) + 0.5)));
        end
        forever begin
            @(posedge clk);
            #1;
            if (wave_en) begin
                wave_sin = sin_tab[ph];
                wave_cos = cos_tab[ph];
                ph = (ph + 1) % PER;
            end
        end
    end

    initial begin
        reset = 1'b1; wave_en = 1'b0;
        dc_sin = '0; dc_cos = '0;
        addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_error", 32'(err), 32'h0);
        check("reset_rdata", rdata, 32'h0);

        // Register reads after reset
        reg_rd(8'h00); check("id", rdata, 32'h12345678);
        reg_rd(8'h07); check("clr_reads0", rdata, 32'h0);
        reg_rd(8'h02); check("ovr_reset", rdata, 32'h1FFF);
        reg_rd(8'h05); check("dmin_reset", rdata, 32'h1FFF);
        reg_rd(8'h20); check("unmapped", rdata, 32'h0);

        // Simultaneous read/write of one address returns the old value
        addr = 8'h01; wdata = 32'h55; wr = 1'b1; rd = 1'b1;
        tick(1);
        wr = 1'b0; rd = 1'b0;
        check("rw_old", rdata, 32'h0);
        reg_rd(8'h01); check("rw_new", rdata, 32'h55);
        reg_wr(8'h01, 32'h0);
        reg_wr(8'h03, 32'hFFFF_1FFF);
        reg_rd(8'h03); check("thr_trunc", rdata, 32'h1FFF);

        // Clipping
        reg_wr(8'h06, 32'hFF);
        reg_wr(8'h07, 32'hFF);
        dc_sin = 14'h1000; dc_cos = 14'h1000;
        tick(200);
        check("dc_noerr", 32'(err), 32'h0);
        dc_sin = 14'h1FFF;
        tick(1);
        check("clip_lat1", 32'(err[0]), 32'h0);
        tick(1);
        check("clip_pos", 32'(err[0]), 32'(CLIP));
        dc_sin = 14'h1000;
        tick(2);
        reg_wr(8'h07, 32'h01);
        tick(1);
        check("clip_clr", 32'(err[0]), 32'h0);
        dc_cos = 14'h2000;
        tick(2);
        check("clip_neg", 32'(err[0]), 32'(CLIP));
        tick(3);
        dc_cos = 14'h1000;
        tick(2 * WL + 5);
        // |0x2000| = 8192 exceeds the 0x1FFF overrange threshold
        check("ovr_8192", 32'(err), 32'(8'h04 | 8'(CLIP)));
        reg_wr(8'h07, 32'hFF);
        tick(1);
        check("clr_all", 32'(err), 32'h0);

        // Sinusoids
        reg_wr(8'h01, 32'h0100);
        reg_wr(8'h03, 32'h1000);
        wave_en = 1'b1;
        tick(WL);
        reg_wr(8'h07, 32'hFF);
        tick(3 * WL);
        check("sine_noerr", 32'(err), 32'h0);

        reg_wr(8'h01, 32'h1FFF);
        reg_wr(8'h07, 32'hFF);
        tick(3 * WL);
        check("los", 32'(err), 32'h02);

        reg_wr(8'h01, 32'h0100);
        reg_wr(8'h02, 32'h0100);
        reg_wr(8'h07, 32'hFF);
        tick(3 * WL);
        check("ovr", 32'(err), 32'h04);

        reg_wr(8'h02, 32'h1FFF);
        reg_wr(8'h03, 32'h0000);
        reg_wr(8'h04, 32'h0);
        reg_wr(8'h05, 32'h1FFF);
        reg_wr(8'h07, 32'hFF);
        tick(3 * WL);
        check("mismatch", 32'(err), 32'h08);
        reg_rd(8'h04); check("dos_max", rdata, 32'd4100);
        reg_rd(8'h05); check("dos_min", rdata, 32'd4076);

        // Masking and clear/detect collision
        wave_en = 1'b0;
        dc_sin = 14'h1000; dc_cos = 14'h1000;
        reg_wr(8'h03, 32'h1FFF);
        reg_wr(8'h06, 32'h00);
        reg_wr(8'h07, 32'hFF);
        tick(2 * WL + 5);
        dc_sin = 14'h1FFF;
        tick(5);
        check("masked", 32'(err), 32'h0);
        dc_sin = 14'h1000;
        tick(3);
        reg_wr(8'h06, 32'hFF);
        reg_rd(8'h06); check("mask_rd", rdata, 32'hFF);
        check("masked_nolatch", 32'(err), 32'h0);
        dc_sin = 14'h1FFF;
        tick(3);
        check("clip_again", 32'(err[0]), 32'(CLIP));
        reg_wr(8'h07, 32'h01);
        check("clr_vs_detect", 32'(err[0]), 32'(CLIP));
        dc_sin = 14'h1000;
        tick(2);
        reg_wr(8'h07, 32'hFF);
        tick(1);
        check("final_clr", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rdc_fault_monitor.md
# rdc_fault_monitor

Fault-detection and register-bank block of the resolver-to-digital converter (`rdc_top`). It watches the two demodulator input channels (sin, cos ADC samples), measures per-window peak amplitudes, and raises sticky clipping, loss-of-signal, overrange and mismatch flags. All thresholds, the enable mask and the error-clear command are reached through a simple strobe-based register interface.

## Interface
- `ADC_RESOLUTION`, 14, sample width, two's complement
- `ADDR_WIDTH`, 8, register address width
- `DATA_WIDTH`, 32, register data width
- `WINDOW_LEN`, 4000, samples per peak-measurement window (100 µs at 40 MHz)
- `ID_VALUE`, 32'h12345678, constant returned at address 0x00
- `clk_i`  in  1  system clock; the only clock
- `reset_i`  in  1  synchronous, active-high reset
- `sin_signal_i`  in  ADC_RESOLUTION  sin channel sample, one per clock
- `cos_signal_i`  in  ADC_RESOLUTION  cos channel sample, one per clock
- `reg_addr_i`  in  ADDR_WIDTH  register address
- `reg_data_i`  in  DATA_WIDTH  write data
- `reg_write_i`  in  1  write strobe, one cycle
- `reg_read_i`  in  1  read strobe, one cycle
- `reg_data_o`  out  DATA_WIDTH  registered read data
- `error_o`  out  8  masked sticky error flags

## Operation
- Register map (thresholds hold ADC_RESOLUTION bits, unsigned, reads zero-extended):
  - 0x00 ID (RO, ID_VALUE); 0x01 LOS threshold (reset 0); 0x02 overrange threshold (reset 0x1FFF); 0x03 mismatch threshold (reset 0x1FFF)
  - 0x04 DOS max tracker (reset 0), 0x05 DOS min tracker (reset 0x1FFF): RW, hardware updates to the largest/smallest window peak seen; writes reload them
  - 0x06 enable mask (bits 7:0, reset 0x00); 0x07 error clear (write-1-to-clear per bit, reads 0); unmapped addresses read 0, writes ignored
- Clipping (bit 0): either sample equals max positive (0x1FFF) or most negative (0x2000).
- Window peak: |sample| magnitude (ADC_RESOLUTION-bit unsigned, |0x2000| = 8192) maximum per channel over WINDOW_LEN samples; at window end peaks `Ps`, `Pc` are latched and accumulators restart.
- LOS (bit 1): max(Ps,Pc) < LOS threshold.
- Overrange (bit 2): max(Ps,Pc) > overrange threshold.
- Mismatch (bit 3): |Ps − Pc| > mismatch threshold.
- Bits 7:4 reserved, always 0.
- Flags are sticky; a condition latches its bit only when the corresponding mask bit is 1. `error_o` = latched & mask.
- Clear: bits set in a 0x07 write clear the latch; a detection in the same cycle wins (bit stays set).

## Timing
- Reset: `error_o` = 0, `reg_data_o` = 0, all registers to reset values, window counter and peak accumulators to 0.
- Writes take effect on the rising edge where `reg_write_i` = 1.
- `reg_data_o` loads on the edge where `reg_read_i` = 1 and holds until the next read; simultaneous read/write of one address returns the old value.
- Clipping: input sample registered, flag visible on `error_o` 2 cycles after the sample is applied.
- Peak faults: evaluated once per window, visible 2 cycles after window end; worst-case detection latency 2·WINDOW_LEN + 2 cycles after a threshold change.
- Threshold changes mid-window apply at the next evaluation; reset mid-window discards partial peaks.

## Configuration
- `RDC_CLIP_DETECT_EN`: defined → clipping comparator active on bit 0. Undefined → no clip logic, bit 0 always 0, clear/mask on bit 0 have no effect.

## Test plan
- Read 0x00 after reset → `reg_data_o` = 0x12345678; read 0x07 → 0.
- Mask 0xFF, clear 0xFF, both inputs 0x1000 for 5 µs → `error_o[0]` = 0; sin = 0x1FFF → bit 0 = 1 within 2 cycles; clear, cos = 0x2000 → bit 0 = 1.
- 10 kHz sinusoids, amplitudes 4100 (sin) / 4076 (cos), LOS threshold 0x0100 for 1 ms → bit 1 = 0; threshold 0x1FFF, clear, 1 ms → bit 1 = 1.
- Same stimulus, overrange threshold 0x1FFF → bit 2 = 0; 0x0100 → bit 2 = 1.
- Same stimulus, mismatch threshold 0x1000 → bit 3 = 0; 0x0000 → bit 3 = 1 (delta 24); 0x04 reads ≈4100, 0x05 ≈4076.
- Mask 0x00 with clipping input → `error_o` = 0; clear write coinciding with active clip → bit stays latched.
